// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with memory-pointer register-file access
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       addr_hit
);

    // Fewer than two synchronizer flops is never safe, so clamp the depth.
    localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_t;

    logic [NSYNC-1:0] scl_sync_q, scl_sync_d;
    logic [NSYNC-1:0] sda_sync_q, sda_sync_d;
    logic             scl_prev_q, scl_prev_d;
    logic             sda_prev_q, sda_prev_d;
    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       pointer_q, pointer_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             hit_q, hit_d;
    logic             rw_q, rw_d;
    logic             first_q, first_d;
    logic             ack_q, ack_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall;
    logic       start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_s     = scl_sync_q[NSYNC-1];
    assign sda_s     = sda_sync_q[NSYNC-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    // Bus conditions need SCL stably high across both samples of SDA.
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = pointer_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign busy      = busy_q;
    assign addr_hit  = hit_q;

    // Next-state, bus-condition handling and output updates.
    always_comb begin
        scl_sync_d = {scl_sync_q[NSYNC-2:0], scl_in};
        sda_sync_d = {sda_sync_q[NSYNC-2:0], sda_in};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pointer_d  = pointer_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        hit_d      = 1'b0;
        rw_d       = rw_q;
        first_d    = first_q;
        ack_d      = ack_q;

        // The pointer advances the cycle after the write strobe so reg_addr
        // still shows the written location while reg_we is high.
        if (we_q) begin
            pointer_d = pointer_q + 8'd1;
        end

        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            ack_d    = 1'b0;
        end else if (start_det) begin
            // SDA cannot fall while we pull it low, so releasing here never
            // moves sda_oe during an SCL high period in practice.
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            busy_d    = 1'b1;
            sda_oe_d  = 1'b0;
            ack_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == TARGET_ADDR) begin
                                hit_d   = 1'b1;
                                rw_d    = rx_byte[0];
                                ack_d   = 1'b0;
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, WR_ACK: begin
                    // First fall starts the ACK slot, second fall ends it.
                    if (scl_fall) begin
                        if (!ack_q) begin
                            sda_oe_d = 1'b1;
                            ack_d    = 1'b1;
                        end else begin
                            ack_d     = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                shift_d  = reg_rdata;
                                sda_oe_d = ~reg_rdata[7];
                                state_d  = RD_BYTE;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = WR_BYTE;
                                if (state_q == ADDR_ACK) begin
                                    first_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_d   = 1'b0;
                            state_d = WR_ACK;
                            if (first_q) begin
                                pointer_d = rx_byte;
                                first_d   = 1'b0;
                            end else begin
                                wdata_d = rx_byte;
                                we_d    = 1'b1;
                            end
                        end
                    end
                end
                RD_BYTE: begin
                    // Bit 7 went out at the end of the ACK slot; each fall
                    // here closes one bit window and opens the next.
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            ack_d     = 1'b0;
                            state_d   = RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    // Every transmitted byte advances the pointer; the next
                    // byte is fetched from the new address before the fall.
                    if (scl_rise && !ack_q) begin
                        pointer_d = pointer_q + 8'd1;
                        if (sda_s) begin
                            state_d = IGNORE;
                        end else begin
                            ack_d = 1'b1;
                        end
                    end else if (scl_fall && ack_q) begin
                        ack_d     = 1'b0;
                        shift_d   = reg_rdata;
                        sda_oe_d  = ~reg_rdata[7];
                        bit_cnt_d = 3'd0;
                        state_d   = RD_BYTE;
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State registers; synchronizers reset to the idle-high bus level.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            pointer_q  <= 8'd0;
            wdata_q    <= 8'd0;
            we_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            hit_q      <= 1'b0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            pointer_q  <= pointer_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            hit_q      <= hit_d;
            rw_q       <= rw_d;
            first_q    <= first_d;
            ack_q      <= ack_d;
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed bench for i2c_target
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_ctrl;
    logic       sda_ctrl;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       addr_hit;

    int passed = 0;
    int total  = 0;
    int hit_cnt = 0;
    int oe_cnt  = 0;
    logic [15:0] wlog[$];

    assign sda_line = sda_ctrl & ~sda_oe;

    i2c_target #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_ctrl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .addr_hit  (addr_hit)
    );

    always #5 clk = ~clk;

    // Register file read port: data follows the address one cycle later.
    always @(posedge clk) begin
        case (reg_addr)
            8'h20:   reg_rdata <= 8'h3C;
            8'h21:   reg_rdata <= 8'hC3;
            default: reg_rdata <= ~reg_addr;
        endcase
    end

    // Record strobes and drive activity away from the active edge.
    always @(negedge clk) begin
        if (reg_we) wlog.push_back({reg_addr, reg_wdata});
        if (addr_hit) hit_cnt = hit_cnt + 1;
        if (sda_oe) oe_cnt = oe_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_ctrl = 1'b0; wclk(8);
        scl_ctrl = 1'b0; wclk(4);
    endtask

    task automatic i2c_rstart();
        sda_ctrl = 1'b1; wclk(4);
        scl_ctrl = 1'b1; wclk(8);
        i2c_start();
    endtask

    task automatic i2c_stop();
        sda_ctrl = 1'b0; wclk(4);
        scl_ctrl = 1'b1; wclk(8);
        sda_ctrl = 1'b1; wclk(8);
    endtask

    task automatic send_bit(input logic b);
        sda_ctrl = b;    wclk(4);
        scl_ctrl = 1'b1; wclk(8);
        scl_ctrl = 1'b0; wclk(4);
    endtask

    task automatic recv_bit(output logic b);
        sda_ctrl = 1'b1; wclk(4);
        scl_ctrl = 1'b1; wclk(4);
        b = sda_line;    wclk(4);
        scl_ctrl = 1'b0; wclk(4);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        acked = ~b;
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd0, rd1;
        logic [7:0] addr_a0;
        int         h0, w0, o0;
        bit         seen;

        reset = 1'b1; scl_ctrl = 1'b1; sda_ctrl = 1'b1;
        wclk(4);
        check("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
        check("rst_reg_we", {15'd0, reg_we}, 16'd0);
        check("rst_reg_addr", {8'd0, reg_addr}, 16'h0000);
        check("rst_reg_wdata", {8'd0, reg_wdata}, 16'h0000);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_addr_hit", {15'd0, addr_hit}, 16'd0);
        reset = 1'b0;
        wclk(8);

        // Test 1: plain write of two data bytes at pointer 0x10.
        h0 = hit_cnt; w0 = wlog.size();
        i2c_start();
        check("t1_busy_start", {15'd0, busy}, 16'd1);
        wr_byte(8'hA0, ack); check("t1_ack_addr", {15'd0, ack}, 16'd1);
        wr_byte(8'h10, ack); check("t1_ack_ptr", {15'd0, ack}, 16'd1);
        wr_byte(8'hA5, ack); check("t1_ack_d0", {15'd0, ack}, 16'd1);
        wr_byte(8'h5A, ack); check("t1_ack_d1", {15'd0, ack}, 16'd1);
        i2c_stop();
        check("t1_busy_stop", {15'd0, busy}, 16'd0);
        check("t1_hits", 16'(hit_cnt - h0), 16'd1);
        check("t1_we_count", 16'(wlog.size() - w0), 16'd2);
        check("t1_write0", wlog[w0], 16'h10A5);
        check("t1_write1", wlog[w0 + 1], 16'h115A);
        check("t1_ptr", {8'd0, reg_addr}, 16'h0012);

        // Test 2: random read, ACK first byte then NACK.
        w0 = wlog.size();
        i2c_start();
        wr_byte(8'hA0, ack); check("t2_ack_addr", {15'd0, ack}, 16'd1);
        wr_byte(8'h20, ack); check("t2_ack_ptr", {15'd0, ack}, 16'd1);
        i2c_rstart();
        addr_a0 = 8'hA1;
        wr_byte(addr_a0, ack); check("t2_ack_raddr", {15'd0, ack}, 16'd1);
        rd_byte(rd0, 1'b1);
        rd_byte(rd1, 1'b0);
        i2c_stop();
        check("t2_rd0", {8'd0, rd0}, 16'h003C);
        check("t2_rd1", {8'd0, rd1}, 16'h00C3);
        check("t2_ptr", {8'd0, reg_addr}, 16'h0022);
        check("t2_no_we", 16'(wlog.size() - w0), 16'd0);
        check("t2_busy", {15'd0, busy}, 16'd0);

        // Test 3: another address must be ignored completely.
        h0 = hit_cnt; w0 = wlog.size(); o0 = oe_cnt;
        i2c_start();
        wr_byte(8'hA2, ack); check("t3_nack_addr", {15'd0, ack}, 16'd0);
        wr_byte(8'h00, ack); check("t3_nack_data", {15'd0, ack}, 16'd0);
        i2c_stop();
        check("t3_oe_never", 16'(oe_cnt - o0), 16'd0);
        check("t3_no_hit", 16'(hit_cnt - h0), 16'd0);
        check("t3_no_we", 16'(wlog.size() - w0), 16'd0);

        // Test 4: pointer wraps from 0xFF to 0x00.
        w0 = wlog.size();
        i2c_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'hFF, ack);
        wr_byte(8'h11, ack);
        wr_byte(8'h22, ack); check("t4_ack_last", {15'd0, ack}, 16'd1);
        i2c_stop();
        check("t4_we_count", 16'(wlog.size() - w0), 16'd2);
        check("t4_write0", wlog[w0], 16'hFF11);
        check("t4_write1", wlog[w0 + 1], 16'h0022);
        check("t4_ptr", {8'd0, reg_addr}, 16'h0001);

        // Test 5: STOP half-way through a data byte.
        w0 = wlog.size();
        i2c_start();
        wr_byte(8'hA0, ack);
        wr_byte(8'h30, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        wclk(4);
        check("t5_no_we", 16'(wlog.size() - w0), 16'd0);
        check("t5_busy", {15'd0, busy}, 16'd0);
        check("t5_sda_oe", {15'd0, sda_oe}, 16'd0);
        check("t5_ptr", {8'd0, reg_addr}, 16'h0030);

        // Test 6: reset while the address ACK is being driven.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(addr_a0[i] & (i != 0));
        sda_ctrl = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            wclk(1);
            if (sda_oe) seen = 1'b1;
        end
        check("t6_ack_driven", {15'd0, seen}, 16'd1);
        reset = 1'b1;
        wclk(1);
        check("t6_sda_released", {15'd0, sda_oe}, 16'd0);
        check("t6_busy_reset", {15'd0, busy}, 16'd0);
        reset = 1'b0;
        wclk(4);
        w0 = wlog.size();
        i2c_rstart();
        wr_byte(8'hA0, ack); check("t6_ack_addr", {15'd0, ack}, 16'd1);
        wr_byte(8'h05, ack);
        wr_byte(8'h77, ack);
        i2c_stop();
        check("t6_we_count", 16'(wlog.size() - w0), 16'd1);
        check("t6_write", wlog[w0], 16'h0577);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
